xpb_accum_seq: RTL

//  Sequences the shared XPB lookup bank during modular-square reduction.

---
 rtl/xpb_accum_seq.sv | 100 ++++++++++
 1 files changed

// File: rtl/xpb_accum_seq.sv
// xpb_accum_seq: walks NUM_SEG digit/segment pairs through the shared XPB
// lookup bank, accumulates base + selected XPB words, and offers the sum
// downstream on a valid/ready handshake.
module xpb_accum_seq #(
    parameter int NUM_SEG    = 8,
    parameter int DIGIT_BITS = 5,
    parameter int XPB_BITS   = 1024,
    parameter int ACC_BITS   = 1028,
    parameter int SEG_W      = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic [XPB_BITS-1:0]           base_i,
    input  logic [NUM_SEG*DIGIT_BITS-1:0] digits_i,
    output logic                          busy_o,
    output logic [SEG_W-1:0]              seg_sel_o,
    output logic [DIGIT_BITS-1:0]         digit_o,
    input  logic [XPB_BITS-1:0]           xpb_i,
    output logic [ACC_BITS-1:0]           acc_o,
    output logic                          valid_o,
    input  logic                          ready_i
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam int PAD = ACC_BITS - XPB_BITS;

    state_t                          state, state_nxt;
    logic [SEG_W-1:0]                idx;
    logic [NUM_SEG*DIGIT_BITS-1:0]   digits_q;
    logic [ACC_BITS-1:0]             acc;
    logic [DIGIT_BITS-1:0]           cur_digit;
    logic                            last_seg;

    assign cur_digit = digits_q[idx*DIGIT_BITS +: DIGIT_BITS];
    assign last_seg  = (idx == SEG_W'(NUM_SEG - 1));
    assign acc_o     = acc;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and lookup/handshake outputs; lookup selects are forced
    // to zero outside RUN so the bank sees a quiet address when unused.
    always_comb begin
        state_nxt = state;
        seg_sel_o = '0;
        digit_o   = '0;
        busy_o    = 1'b0;
        valid_o   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = RUN;
            end
            RUN: begin
                busy_o    = 1'b1;
                seg_sel_o = idx;
                digit_o   = cur_digit;
                if (last_seg) state_nxt = HOLD;
            end
            HOLD: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                if (ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on start, add one XPB word per RUN cycle.
    // Zero digits skip the add but still spend the cycle, keeping latency
    // independent of the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            digits_q <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        digits_q <= digits_i;
                        acc      <= {{PAD{1'b0}}, base_i};
                        idx      <= '0;
                    end
                end
                RUN: begin
                    if (cur_digit != '0)
                        acc <= acc + {{PAD{1'b0}}, xpb_i};
                    idx <= last_seg ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
